// File: rtl/cache_dre_clr_ctrl_pkg.sv
// Shared types and constants for the DRE clear sequencer: FSM states,
// channel count, clear value and the line-index width helper.
package cache_dre_pkg;

    typedef enum logic [1:0] {
        S_SWEEP = 2'd0,
        S_IDLE  = 2'd1,
        S_INV   = 2'd2
    } clr_state_e;

    localparam int         DRE_CHANNELS  = 4;
    localparam logic [7:0] DRE_CLR_VALUE = 8'h00;

    // Line index width: RAM row bits minus the rows-within-a-line bits.
    function automatic int calc_lw(input int addr_width, input int line_rows);
        return addr_width - 1 - $clog2(line_rows);
    endfunction

endpackage

// File: rtl/cache_dre_clr_ctrl_if.sv
// Request/response and DRE write-port bundle of the clear sequencer.
// master = the sequencer itself, slave = the surrounding cache logic.
interface cache_dre_clr_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_ROWS  = 4
);
    import cache_dre_pkg::*;

    localparam int LW   = calc_lw(ADDR_WIDTH, LINE_ROWS);
    localparam int CH_W = $clog2(DRE_CHANNELS);

    logic                  flush_req;
    logic                  flush_busy;
    logic                  init_done;
    logic                  inv_req;
    logic                  inv_ready;
    logic [LW-1:0]         inv_line;
    logic [CH_W-1:0]       inv_channel;
    logic                  inv_done;
    logic                  sel;
    logic                  rw_stall;
    logic [ADDR_WIDTH-1:0] ri_writeAddress;
    logic [CH_W-1:0]       ri_writeChannel;
    logic                  ri_writeEnable;
    logic [7:0]            ri_writeData;

    modport master (
        input  flush_req, inv_req, inv_line, inv_channel,
        output flush_busy, init_done, inv_ready, inv_done, sel, rw_stall,
               ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData
    );

    modport slave (
        output flush_req, inv_req, inv_line, inv_channel,
        input  flush_busy, init_done, inv_ready, inv_done, sel, rw_stall,
               ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData
    );

endinterface

// File: rtl/cache_dre_clr_ctrl.sv
// Owns the DRE write port: sweeps all rows/channels to "not readable" after
// reset and on flush, and clears a single line of one channel on eviction.
module cache_dre_clr_ctrl
    import cache_dre_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_ROWS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    cache_dre_clr_ctrl_if.master bus
);
    localparam int LW    = calc_lw(ADDR_WIDTH, LINE_ROWS);
    localparam int LRB   = $clog2(LINE_ROWS);
    localparam int ROW_W = ADDR_WIDTH - 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int CH_W  = $clog2(DRE_CHANNELS);

    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(LINE_ROWS - 1);
    localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(LINE_ROWS - 1);

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    line_q, line_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             init_done_q, init_done_d;

    logic             inv_ready;
    logic             inv_last;
    logic [ROW_W-1:0] inv_row;

    assign inv_ready = (state_q == S_IDLE) && init_done_q && !bus.flush_req;
    assign inv_last  = (state_q == S_INV) && (cnt_q == INV_LAST);
    // Works for LINE_ROWS == 1 too, where no counter bits enter the row.
    assign inv_row   = (ROW_W'(line_q) << LRB) | (cnt_q[ROW_W-1:0] & ROW_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SWEEP;
            cnt_q       <= '0;
            line_q      <= '0;
            ch_q        <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            ch_q        <= ch_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        line_d      = line_q;
        ch_d        = ch_q;
        init_done_d = init_done_q;
        case (state_q)
            S_SWEEP: begin
                // A flush seen mid-sweep restarts it, so no request is dropped.
                if (bus.flush_req) begin
                    cnt_d = '0;
                end else if (&cnt_q) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_INV: begin
                if (inv_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d = '0;
                if (bus.flush_req) begin
                    state_d = S_SWEEP;
                end else if (bus.inv_req && inv_ready) begin
                    state_d = S_INV;
                    line_d  = bus.inv_line;
                    ch_d    = bus.inv_channel;
                end
            end
        endcase
    end

    always_comb begin
        bus.sel             = 1'b0;
        bus.rw_stall        = 1'b0;
        bus.ri_writeEnable  = 1'b0;
        bus.ri_writeAddress = '0;
        bus.ri_writeChannel = '0;
        bus.flush_busy      = 1'b0;
        case (state_q)
            S_SWEEP: begin
                bus.sel             = 1'b1;
                bus.rw_stall        = 1'b1;
                bus.ri_writeEnable  = 1'b1;
                bus.ri_writeAddress = {cnt_q[CNT_W-1:2], 1'b0};
                bus.ri_writeChannel = cnt_q[1:0];
                bus.flush_busy      = 1'b1;
            end
            S_INV: begin
                bus.sel             = 1'b1;
                bus.rw_stall        = 1'b1;
                bus.ri_writeEnable  = 1'b1;
                bus.ri_writeAddress = {inv_row, 1'b0};
                bus.ri_writeChannel = ch_q;
            end
            default: ;
        endcase
    end

    assign bus.ri_writeData = DRE_CLR_VALUE;
    assign bus.inv_ready    = inv_ready;
    assign bus.inv_done     = inv_last;
    assign bus.init_done    = init_done_q;

endmodule

// File: tb/tb_cache_dre_clr_ctrl.sv
// Scoreboard bench for cache_dre_clr_ctrl at ADDR_WIDTH=4, LINE_ROWS=2
// (8 rows, 32-cycle sweep) with a shadow model of DRE readability.
module tb_cache_dre_clr_ctrl;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] ch;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_got;
    exp_t mon_exp;
    logic [3:0] shadow [8];

    always #5 clk = ~clk;

    cache_dre_clr_ctrl_if #(.ADDR_WIDTH(4), .LINE_ROWS(2)) bus ();

    cache_dre_clr_ctrl #(.ADDR_WIDTH(4), .LINE_ROWS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Write monitor: every DRE write is popped from the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.rw_stall !== bus.sel) begin
                errors++;
                $display("FAIL stall_eq_sel rw_stall=%b sel=%b", bus.rw_stall, bus.sel);
            end
            if (bus.sel === 1'b1) begin
                mon_got = '{addr: bus.ri_writeAddress, ch: bus.ri_writeChannel, last: bus.inv_done};
                checks++;
                if (bus.ri_writeEnable !== 1'b1 || bus.ri_writeData !== 8'h00) begin
                    errors++;
                    $display("FAIL write_strobe we=%b data=%h required we=1 data=00",
                             bus.ri_writeEnable, bus.ri_writeData);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d ch=%0d inv_done=%b required no write",
                             mon_got.addr, mon_got.ch, mon_got.last);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL write addr=%0d ch=%0d inv_done=%b required addr=%0d ch=%0d inv_done=%b",
                                 mon_got.addr, mon_got.ch, mon_got.last,
                                 mon_exp.addr, mon_exp.ch, mon_exp.last);
                    end else begin
                        $display("write addr=%0d ch=%0d inv_done=%b ok", mon_got.addr, mon_got.ch, mon_got.last);
                    end
                end
                if (bus.ri_writeEnable === 1'b1) begin
                    shadow[bus.ri_writeAddress[3:1]] &= ~(4'h8 >> bus.ri_writeChannel);
                end
            end else begin
                checks++;
                if (bus.ri_writeEnable !== 1'b0 || bus.inv_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_quiet we=%b inv_done=%b required 0 0",
                             bus.ri_writeEnable, bus.inv_done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int n);
        exp_t e;
        logic [4:0] c;
        for (int i = 0; i < n; i++) begin
            c      = 5'(i);
            e.addr = {c[4:2], 1'b0};
            e.ch   = c[1:0];
            e.last = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_inv(input logic [1:0] line, input logic [1:0] ch);
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            e.addr = {line, (r == 1), 1'b0};
            e.ch   = ch;
            e.last = (r == 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_shadow();
        for (int r = 0; r < 8; r++) shadow[r] = 4'($urandom_range(1, 15));
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending_writes=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL %s_init_latency cycles=%0d required 32", name, n);
        end else begin
            $display("%s init_done after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        bus.flush_req   = 1'b0;
        bus.inv_req     = 1'b0;
        bus.inv_line    = '0;
        bus.inv_channel = '0;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.sel, bus.rw_stall, bus.ri_writeEnable, bus.flush_busy,
             bus.inv_ready, bus.init_done, bus.inv_done} !== 7'b1111000) begin
            errors++;
            $display("FAIL reset_flags sel/stall/we/busy/ready/init/done=%b required 1111000",
                     {bus.sel, bus.rw_stall, bus.ri_writeEnable, bus.flush_busy,
                      bus.inv_ready, bus.init_done, bus.inv_done});
        end
        checks++;
        if (bus.ri_writeAddress !== 4'd0 || bus.ri_writeChannel !== 2'd0) begin
            errors++;
            $display("FAIL reset_bus addr=%0d ch=%0d required 0 0",
                     bus.ri_writeAddress, bus.ri_writeChannel);
        end
        fill_shadow();
        push_sweep(32);
        rst = 1'b0;
        wait_init("reset");
        repeat (4) tick();
        check_drained("reset");
    endtask

    task automatic test_inv();
        fill_shadow();
        bus.inv_line    = 2'd2;
        bus.inv_channel = 2'd1;
        bus.inv_req     = 1'b1;
        #1;
        checks++;
        if (bus.inv_ready !== 1'b1) begin
            errors++;
            $display("FAIL inv_ready_idle inv_ready=%b required 1", bus.inv_ready);
        end
        push_inv(2'd2, 2'd1);
        tick();
        bus.inv_req = 1'b0;
        checks++;
        if (bus.sel !== 1'b1 || bus.inv_ready !== 1'b0) begin
            errors++;
            $display("FAIL inv_busy sel=%b inv_ready=%b required 1 0", bus.sel, bus.inv_ready);
        end
        tick();
        tick();
        checks++;
        if (bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL inv_release sel=%b required 0", bus.sel);
        end
        check_drained("inv");
        checks++;
        if (shadow[4][2] !== 1'b0 || shadow[5][2] !== 1'b0) begin
            errors++;
            $display("FAIL inv_shadow row4=%b row5=%b required ch1 bit clear", shadow[4], shadow[5]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.inv_line    = 2'd0;
        bus.inv_channel = 2'd0;
        bus.inv_req     = 1'b1;
        push_inv(2'd0, 2'd0);
        push_inv(2'd1, 2'd2);
        #1;
        tick();
        bus.inv_line    = 2'd1;
        bus.inv_channel = 2'd2;
        n = 0;
        while (bus.inv_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_gap cycles=%0d required 2", n);
        end
        tick();
        bus.inv_req = 1'b0;
        tick();
        tick();
        check_drained("b2b");
    endtask

    task automatic test_flush_and_inv();
        int  n;
        logic readable;
        fill_shadow();
        bus.flush_req   = 1'b1;
        bus.inv_req     = 1'b1;
        bus.inv_line    = 2'd3;
        bus.inv_channel = 2'd2;
        #1;
        checks++;
        if (bus.inv_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_prio inv_ready=%b required 0", bus.inv_ready);
        end
        push_sweep(32);
        push_inv(2'd3, 2'd2);
        tick();
        bus.flush_req = 1'b0;
        n = 0;
        while (bus.inv_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL flush_inv_wait cycles=%0d required 32", n);
        end
        tick();
        bus.inv_req = 1'b0;
        tick();
        tick();
        check_drained("flush_inv");
        for (int r = 0; r < 8; r++) begin
            readable = 1'b0;
            for (int be = 1; be < 16; be++) begin
                if ((shadow[r] & 4'(be)) != 4'd0) readable = 1'b1;
            end
            checks++;
            if (readable !== 1'b0) begin
                errors++;
                $display("FAIL flush_readable row=%0d mask=%b required isReadable=0", r, shadow[r]);
            end
        end
    endtask

    task automatic test_flush_restart();
        int busy;
        bus.flush_req = 1'b1;
        tick();
        push_sweep(20);
        push_sweep(32);
        busy = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.flush_busy !== 1'b1) break;
            busy++;
            bus.flush_req = (busy == 20);
            tick();
        end
        bus.flush_req = 1'b0;
        checks++;
        if (busy != 52) begin
            errors++;
            $display("FAIL restart_busy cycles=%0d required 52", busy);
        end
        checks++;
        if (bus.init_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_init_sticky init_done=%b required 1", bus.init_done);
        end
        repeat (5) tick();
        checks++;
        if (bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_single_exit flush_busy=%b required 0", bus.flush_busy);
        end
        check_drained("restart");
    endtask

    task automatic test_rst_mid_inv();
        bus.inv_line    = 2'd1;
        bus.inv_channel = 2'd3;
        bus.inv_req     = 1'b1;
        #1;
        tick();
        bus.inv_req = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.ri_writeAddress !== 4'd0 || bus.ri_writeChannel !== 2'd0 ||
            bus.init_done !== 1'b0 || bus.inv_done !== 1'b0 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort addr=%0d ch=%0d init=%b inv_done=%b sel=%b required 0 0 0 0 1",
                     bus.ri_writeAddress, bus.ri_writeChannel, bus.init_done, bus.inv_done, bus.sel);
        end
        push_sweep(32);
        rst = 1'b0;
        wait_init("rst_mid_inv");
        repeat (3) tick();
        check_drained("rst_mid_inv");
    endtask

    initial begin
        test_reset();
        test_inv();
        test_back_to_back();
        test_flush_and_inv();
        test_flush_restart();
        test_rst_mid_inv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
